metropolis_acceptor: RTL and testbench
======================================

METROPOLIS_ACCEPTOR -- requirements
Module: metropolis_acceptor

Interface
REQ-001 SHALL provide parameter COST_WIDTH, default 8: width of clause-cost and temperature operands.
REQ-002 SHALL provide parameter LFSR_WIDTH, default 16: width of the internal pseudo-random generator.
REQ-003 in_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 in_reset  input  1  synchronous, active-high reset.
REQ-005 in_start  input  1  request pulse; sampled only in IDLE.
REQ-006 in_current_cost  input  COST_WIDTH  unsatisfied-constraint count of the stored assignment.
REQ-007 in_proposed_cost  input  COST_WIDTH  unsatisfied-constraint count of the proposed assignment.
REQ-008 in_temperature  input  COST_WIDTH  rejection steepness (beta); larger value rejects worsening moves more.
REQ-009 in_seed_load  input  1  loads in_seed into the LFSR.
REQ-010 in_seed  input  LFSR_WIDTH  LFSR seed value.
REQ-011 out_accept  output  1  decision; 1 = proposed assignment replaces stored one.
REQ-012 out_done  output  1  one-cycle pulse; out_accept is valid in that cycle.
REQ-013 out_busy  output  1  high in every state except IDLE.

Function
REQ-014 FSM states SHALL be IDLE, EVAL, SHIFT, DRAW and DONE.
REQ-015 IDLE with in_start=1 SHALL register both costs and in_temperature and go to EVAL; in_start outside IDLE SHALL be ignored.
REQ-016 EVAL with proposed <= current SHALL set accept=1 and go to DONE.
REQ-017 EVAL with proposed > current SHALL compute delta = proposed - current and product = delta*temperature (2*COST_WIDTH bits, no overflow), load count = min(8, product>>4) and threshold = 8'hFF, then go to SHIFT.
REQ-018 SHIFT with count != 0 SHALL shift threshold right by 1, decrement count, and stay in SHIFT; SHIFT with count == 0 SHALL go to DRAW.
REQ-019 DRAW SHALL set accept = (lfsr[7:0] < threshold), unsigned compare, and go to DONE; threshold 0 therefore always rejects.
REQ-020 DONE SHALL drive out_done=1 for exactly one cycle, then return to IDLE.
REQ-021 out_accept SHALL be updated only on entry to DONE and SHALL hold until the next decision.
REQ-022 Latency from the in_start sample cycle N: improving/equal move, out_done high in cycle N+2; worsening move with k=count, out_done high in cycle N+4+k (max N+12).
REQ-023 LFSR SHALL be a Galois LFSR with polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400), advancing every cycle outside reset.
REQ-024 in_seed_load=1 SHALL load in_seed, or 16'h0001 if in_seed==0, and takes priority over advancing in that cycle.
REQ-025 in_seed_load SHALL be honoured in any FSM state without disturbing the FSM.
REQ-026 A new decision SHALL be accepted in the cycle after DONE (back-to-back throughput).

Reset
REQ-027 in_reset=1 SHALL force state IDLE, out_accept=0, out_done=0, out_busy=0, count=0, threshold=0, lfsr=16'hACE1.
REQ-028 Reset asserted mid-operation SHALL abort the decision with no out_done pulse.
REQ-029 Reset SHALL take priority over in_start and in_seed_load.

Verification
REQ-030 current=5, proposed=3, start at N -> out_done at N+2, out_accept=1, out_busy high N+1..N+2.
REQ-031 current=7, proposed=7 -> out_accept=1 at N+2, no LFSR dependence.
REQ-032 current=2, proposed=18, temperature=16 -> count saturates to 8, threshold=0, out_done at N+12, out_accept=0 for 100 seeds.
REQ-033 current=0, proposed=4, temperature=8, seed 16'h1234 -> count=2, threshold=8'h3F, out_done at N+6, out_accept matches reference LFSR model.
REQ-034 in_reset pulsed during SHIFT -> no out_done, all outputs 0, lfsr=16'hACE1; next start completes normally.
REQ-035 in_start re-pulsed while busy, and in_seed_load with in_seed=0 -> extra start ignored, LFSR becomes 16'h0001.

Source files
------------

// File: rtl/metropolis_acceptor.sv
// metropolis_acceptor: Metropolis accept/reject decision for a proposed assignment.
// A worsening move is accepted with probability about 2^-min(8, delta*beta/16).
module metropolis_acceptor #(
    parameter int COST_WIDTH = 8,
    parameter int LFSR_WIDTH = 16
) (
    input  logic                  in_clk,
    input  logic                  in_reset,
    input  logic                  in_start,
    input  logic [COST_WIDTH-1:0] in_current_cost,
    input  logic [COST_WIDTH-1:0] in_proposed_cost,
    input  logic [COST_WIDTH-1:0] in_temperature,
    input  logic                  in_seed_load,
    input  logic [LFSR_WIDTH-1:0] in_seed,
    output logic                  out_accept,
    output logic                  out_done,
    output logic                  out_busy
);
    typedef enum logic [2:0] {IDLE, EVAL, SHIFT, DRAW, DONE} state_t;
    localparam logic [LFSR_WIDTH-1:0] MASK = LFSR_WIDTH'(16'hB400);
    localparam logic [LFSR_WIDTH-1:0] LFSR_INIT = LFSR_WIDTH'(16'hACE1);
    state_t state, state_nx;
    logic [COST_WIDTH-1:0] cur, prop, temp;
    logic [2*COST_WIDTH-1:0] product, scaled;
    logic [3:0] count;
    logic [7:0] threshold;
    logic [LFSR_WIDTH-1:0] lfsr, lfsr_step;
    assign product = {{COST_WIDTH{1'b0}}, prop - cur} * {{COST_WIDTH{1'b0}}, temp};
    assign scaled = product >> 4;
    assign lfsr_step = {1'b0, lfsr[LFSR_WIDTH-1:1]} ^ (lfsr[0] ? MASK : '0);
    assign out_done = state == DONE;
    assign out_busy = state != IDLE;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = in_start ? EVAL : IDLE;
            EVAL:    state_nx = prop <= cur ? DONE : SHIFT;
            SHIFT:   state_nx = count == 4'd0 ? DRAW : SHIFT;
            DRAW:    state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge in_clk) begin
        if (in_reset)
            state <= IDLE;
        else
            state <= state_nx;
    end
    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            cur        <= '0;
            prop       <= '0;
            temp       <= '0;
            count      <= '0;
            threshold  <= '0;
            out_accept <= 1'b0;
            lfsr       <= LFSR_INIT;
        end else begin
            lfsr <= in_seed_load ? (in_seed == '0 ? LFSR_WIDTH'(1) : in_seed) : lfsr_step;
            if (state == IDLE && in_start) begin
                cur  <= in_current_cost;
                prop <= in_proposed_cost;
                temp <= in_temperature;
            end
            if (state == EVAL) begin
                if (prop <= cur) begin
                    out_accept <= 1'b1;
                end else begin
                    count     <= scaled > 8 ? 4'd8 : scaled[3:0];
                    threshold <= 8'hFF;
                end
            end
            if (state == SHIFT && count != 4'd0) begin
                threshold <= threshold >> 1;
                count     <= count - 4'd1;
            end
            if (state == DRAW)
                out_accept <= lfsr[7:0] < threshold;
        end
    end
endmodule

// File: tb/tb_metropolis_acceptor.sv
// tb_metropolis_acceptor: vector table, corner sequences and random decisions
// checked against a latency/probability model derived from the acceptance rules.
module tb_metropolis_acceptor;
    logic        in_clk = 1'b0;
    logic        in_reset, in_start, in_seed_load;
    logic [7:0]  in_current_cost, in_proposed_cost, in_temperature;
    logic [15:0] in_seed;
    logic        out_accept, out_done, out_busy;
    int          tests = 0;
    int          fails = 0;
    logic [15:0] m_lfsr;

    typedef struct {
        logic [7:0] c;
        logic [7:0] p;
        logic [7:0] t;
        int         lat;
        logic [7:0] thr;
    } vec_t;
    vec_t tbl[9];

    metropolis_acceptor dut (
        .in_clk(in_clk), .in_reset(in_reset), .in_start(in_start),
        .in_current_cost(in_current_cost), .in_proposed_cost(in_proposed_cost),
        .in_temperature(in_temperature), .in_seed_load(in_seed_load), .in_seed(in_seed),
        .out_accept(out_accept), .out_done(out_done), .out_busy(out_busy)
    );

    always #5 in_clk = ~in_clk;

    // Reference random source, straight from the polynomial and seeding rules.
    always @(posedge in_clk) begin
        if (in_reset)
            m_lfsr <= 16'hACE1;
        else if (in_seed_load)
            m_lfsr <= in_seed == 16'h0 ? 16'h0001 : in_seed;
        else
            m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic seed(input logic [15:0] v);
        in_seed_load = 1'b1;
        in_seed = v;
        @(negedge in_clk);
        in_seed_load = 1'b0;
    endtask

    // Called at a negedge; issues a start there and follows the decision to the idle cycle after DONE.
    task automatic run(input logic [7:0] c, input logic [7:0] p, input logic [7:0] t,
                       input int lat, input logic [7:0] thr, input bit extra, input string nm);
        logic [7:0] draw = 8'h0;
        bit exp_acc = 1'b0;
        in_current_cost = c;
        in_proposed_cost = p;
        in_temperature = t;
        in_start = 1'b1;
        for (int i = 1; i <= lat + 1; i++) begin
            @(negedge in_clk);
            in_start = 1'b0;
            in_seed_load = 1'b0;
            if (i == lat - 1) draw = m_lfsr[7:0];
            exp_acc = lat == 2 ? 1'b1 : draw < thr;
            check({nm, " done"}, 32'(out_done), 32'(i == lat));
            check({nm, " busy"}, 32'(out_busy), 32'(i <= lat));
            if (i >= lat) check({nm, " accept"}, 32'(out_accept), 32'(exp_acc));
            if (extra && i == 3) check({nm, " seed0 lfsr"}, 32'(dut.lfsr), 32'h0001);
            if (extra && i == 2) begin
                in_start = 1'b1;
                in_seed_load = 1'b1;
                in_seed = 16'h0000;
            end
        end
    endtask

    task automatic run_model(input logic [7:0] c, input logic [7:0] p, input logic [7:0] t, input string nm);
        int prod, k;
        if (p <= c) begin
            run(c, p, t, 2, 8'h00, 1'b0, nm);
        end else begin
            prod = (int'(p) - int'(c)) * int'(t);
            k = prod / 16 > 8 ? 8 : prod / 16;
            run(c, p, t, 4 + k, 8'(255 >> k), 1'b0, nm);
        end
    endtask

    initial begin
        tbl[0] = '{8'd5,   8'd3,   8'd0,   2,  8'h00};
        tbl[1] = '{8'd7,   8'd7,   8'd200, 2,  8'h00};
        tbl[2] = '{8'd2,   8'd18,  8'd16,  12, 8'h00};
        tbl[3] = '{8'd0,   8'd4,   8'd8,   6,  8'h3F};
        tbl[4] = '{8'd3,   8'd4,   8'd15,  4,  8'hFF};
        tbl[5] = '{8'd3,   8'd4,   8'd16,  5,  8'h7F};
        tbl[6] = '{8'd1,   8'd8,   8'd16,  11, 8'h01};
        tbl[7] = '{8'd0,   8'd255, 8'd255, 12, 8'h00};
        tbl[8] = '{8'd200, 8'd0,   8'd255, 2,  8'h00};
        in_reset = 1'b1;
        in_start = 1'b1;
        in_seed_load = 1'b1;
        in_seed = 16'h5555;
        in_current_cost = 8'd0;
        in_proposed_cost = 8'd0;
        in_temperature = 8'd0;
        repeat (3) @(negedge in_clk);
        check("reset accept", 32'(out_accept), 32'h0);
        check("reset done", 32'(out_done), 32'h0);
        check("reset busy", 32'(out_busy), 32'h0);
        check("reset lfsr", 32'(dut.lfsr), 32'hACE1);
        in_reset = 1'b0;
        in_start = 1'b0;
        in_seed_load = 1'b0;
        @(negedge in_clk);

        for (int v = 0; v < 9; v++)
            run(tbl[v].c, tbl[v].p, tbl[v].t, tbl[v].lat, tbl[v].thr, 1'b0, $sformatf("vec%0d", v));

        seed(16'h1234);
        run(8'd0, 8'd4, 8'd8, 6, 8'h3F, 1'b0, "seed1234");

        for (int s = 0; s < 100; s++) begin
            seed(16'(s * 613) ^ 16'h5A5A);
            run(8'd2, 8'd18, 8'd16, 12, 8'h00, 1'b0, "sat_reject");
        end

        in_current_cost = 8'd2;
        in_proposed_cost = 8'd18;
        in_temperature = 8'd16;
        in_start = 1'b1;
        @(negedge in_clk);
        in_start = 1'b0;
        repeat (2) @(negedge in_clk);
        check("mid busy", 32'(out_busy), 32'h1);
        in_reset = 1'b1;
        @(negedge in_clk);
        in_reset = 1'b0;
        check("abort accept", 32'(out_accept), 32'h0);
        check("abort busy", 32'(out_busy), 32'h0);
        check("abort lfsr", 32'(dut.lfsr), 32'hACE1);
        check("abort count", 32'(dut.count), 32'h0);
        check("abort threshold", 32'(dut.threshold), 32'h0);
        for (int i = 0; i < 12; i++) begin
            check("abort done", 32'(out_done), 32'h0);
            @(negedge in_clk);
        end
        run(8'd5, 8'd3, 8'd9, 2, 8'h00, 1'b0, "after_abort");

        run(8'd0, 8'd4, 8'd8, 6, 8'h3F, 1'b1, "restart_ignored");
        check("restart idle", 32'(out_busy), 32'h0);

        for (int r = 0; r < 200; r++) begin
            if ($urandom_range(0, 3) == 0) seed(16'($urandom));
            in_current_cost = 8'($urandom);
            run_model(in_current_cost, 8'($urandom), 8'($urandom_range(0, 40)), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
